// File: rtl/mx_quant_fp8.sv
// mx_quant_fp8: buffers a block of k fixed-point dot-product results and re-quantizes
// them to k FP8 elements sharing one E8M0 scale taken from the largest magnitude.
module mx_quant_fp8 #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int k = 32,
  parameter bit e4m3_spec = (exp_width == 4) && (man_width == 3),
  parameter int in_width = 2*((1<<exp_width)+man_width)+$clog2(k),
  parameter int frac_bits = 2*((1<<(exp_width-1))-2+man_width),
  parameter int bit_width = 1+exp_width+man_width
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [in_width-1:0]  i_data,
  input  logic                 i_nan,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [bit_width-1:0] o_elem,
  output logic [7:0]           o_scale,
  output logic                 o_last
);
  localparam int CW = $clog2(k);
  localparam int QW = in_width + man_width + 1;
  localparam int BIAS = (1 << (exp_width-1)) - 1;
  localparam int EMAX = e4m3_spec ? 8 : BIAS;
  localparam int MAXC = e4m3_spec ? ((((1<<exp_width)-1) << man_width) | ((1<<man_width)-2))
                                  : ((((1<<exp_width)-2) << man_width) | ((1<<man_width)-1));

  typedef enum logic [1:0] {COLLECT, SCALE, EMIT} state_t;
  state_t r_state, w_next;
  logic [in_width-1:0] r_buf [k];
  logic [in_width-1:0] r_mag_or, w_abs;
  logic [CW-1:0] r_cnt, r_idx;
  logic r_nan, r_valid, r_last;
  logic [bit_width-1:0] r_elem;
  logic [7:0] r_scale, w_scale;
  logic signed [9:0] r_x, w_x;
  logic w_hs_in, w_hs_out, w_load;
  int w_sc;

  function automatic int msb(input logic [in_width-1:0] v);
    msb = -1;
    for (int j = 0; j < in_width; j++) if (v[j]) msb = j;
  endfunction

  // q is the rounded magnitude in units of the element LSB; adding it to the
  // shifted field base folds mantissa carry and subnormal-to-normal promotion in.
  function automatic logic [bit_width-1:0] quant(input logic [in_width-1:0] d, input int x);
    logic [in_width-1:0] m, mask, rem, half;
    logic [QW-1:0] q;
    int e, le, sh, code;
    m = d[in_width-1] ? -d : d;
    e = msb(m) - frac_bits - x;
    le = e > 1 - BIAS ? e : 1 - BIAS;
    sh = frac_bits + x + le - man_width;
    q = '0;
    if (sh <= 0) q = QW'(m) << (-sh);
    else if (sh <= in_width) begin
      mask = {in_width{1'b1}} >> (in_width - sh);
      rem = m & mask;
      half = {{(in_width-1){1'b0}}, 1'b1} << (sh - 1);
      q = QW'(m >> sh);
      q = q + QW'(rem > half || (rem == half && q[0]));
    end
    code = (le + BIAS - 1) * (1 << man_width) + int'(q);
    if (code > MAXC) code = MAXC;
    return (q == '0) ? '0 : {d[in_width-1], (bit_width-1)'(code)};
  endfunction

  assign w_abs = i_data[in_width-1] ? -i_data : i_data;
  assign w_hs_in = i_valid && r_state == COLLECT;
  assign w_hs_out = r_valid && i_ready;
  assign w_load = r_state == EMIT && (!r_valid || (i_ready && !r_last));

  always_comb begin
    w_next = r_state;
    if (r_state == COLLECT && w_hs_in && r_cnt == CW'(k-1)) w_next = SCALE;
    if (r_state == SCALE) w_next = EMIT;
    if (r_state == EMIT && w_hs_out && r_last) w_next = COLLECT;
    w_sc = msb(r_mag_or) - frac_bits - EMAX + 127;
    w_sc = w_sc < 0 ? 0 : w_sc > 254 ? 254 : w_sc;
    w_scale = r_nan ? 8'hFF : r_mag_or == '0 ? 8'h00 : 8'(w_sc);
    w_x = r_mag_or == '0 ? -10'sd127 : 10'(w_sc - 127);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= COLLECT;
    else r_state <= w_next;

  always_ff @(posedge i_clk)
    if (w_hs_in) r_buf[r_cnt] <= i_data;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_mag_or <= '0;
      r_nan <= 1'b0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_elem <= '0;
      r_scale <= '0;
      r_x <= '0;
    end else begin
      if (w_hs_in) begin
        r_cnt <= r_cnt + CW'(1);
        r_nan <= r_nan | i_nan;
        r_mag_or <= r_mag_or | w_abs;
      end
      if (r_state == SCALE) begin
        r_scale <= w_scale;
        r_x <= w_x;
        r_idx <= '0;
      end
      if (w_load) begin
        r_elem <= r_nan ? '0 : quant(r_buf[r_idx], int'(r_x));
        r_last <= r_idx == CW'(k-1);
        r_valid <= 1'b1;
        r_idx <= r_idx + CW'(1);
      end else if (w_hs_out) begin
        r_valid <= 1'b0;
        r_last <= 1'b0;
        r_cnt <= '0;
        r_mag_or <= '0;
        r_nan <= 1'b0;
      end
    end

  assign o_ready = r_state == COLLECT;
  assign o_valid = r_valid;
  assign o_elem = r_elem;
  assign o_scale = r_scale;
  assign o_last = r_last;
endmodule

// File: doc/mx_quant_fp8.md
# mx_quant_fp8

Block-level quantizer that converts a block of `k` wide signed fixed-point dot-product results back into MX format: `k` FP8 elements and one shared E8M0 scale. It sits downstream of the FP8 dot-product array and accepts its `o_dp`/`o_nan` pair as a valid/ready stream, one result per beat. It buffers the whole block and derives the shared exponent from the largest magnitude. It then emits the quantized elements as a second valid/ready stream.

## Interface
- `exp_width`, 5, element exponent bits.
- `man_width`, 2, element mantissa bits.
- `k`, 32, elements per MX block.
- `e4m3_spec`, `(exp_width==4)&&(man_width==3)`, selects E4M3 special encoding (no Inf; NaN = all ones).
- `in_width`, `2*((1<<exp_width)+man_width)+$clog2(k)`, input word width.
- `frac_bits`, `2*((1<<(exp_width-1))-2+man_width)`, input binary point; value = `i_data * 2^-frac_bits`.
- `bit_width`, `1+exp_width+man_width`, element width.
- `i_clk  in  1`  clock, all logic on rising edge.
- `i_rst_n  in  1`  asynchronous active-low reset.
- `i_valid  in  1`  input beat valid.
- `o_ready  out  1`  block can accept an input beat.
- `i_data  in  in_width`  signed fixed-point dot-product result.
- `i_nan  in  1`  NaN flag accompanying `i_data`.
- `o_valid  out  1`  output element valid.
- `i_ready  in  1`  downstream accepts element.
- `o_elem  out  bit_width`  FP8 element `{sign, exp, man}`.
- `o_scale  out  8`  shared E8M0 scale, held constant for the whole block.
- `o_last  out  1`  marks element `k-1`.

## Operation
- Constants: `bias = 2^(exp_width-1)-1`. `emax = 8` if `e4m3_spec`, else `bias`. Max normal is exp field `1111` with man `110` for E4M3; otherwise exp field `2^exp_width-2` with all-ones mantissa.
- FSM states: COLLECT, SCALE, EMIT.
- COLLECT:
  - `o_ready=1`. Each handshake (`i_valid && o_ready`) writes `i_data` to `buf[cnt]`, increments `cnt`, and sets a sticky `nan |= i_nan`.
  - `mag_or |= |i_data|`. The MSB of the OR equals the MSB of the maximum magnitude.
  - On the handshake with `cnt==k-1`, go to SCALE.
- SCALE (1 cycle, `o_ready=0`):
  - `p` = MSB index of `mag_or`, and `X = p - frac_bits - emax`.
  - If `nan`: `o_scale=0xFF`.
  - Else if `mag_or==0`: `o_scale=0x00` and `X=-127`.
  - Else: `o_scale = clamp(X+127, 0, 254)`, and X is replaced by the clamped value minus 127.
  - Then go to EMIT with the index reset to 0.
- EMIT:
  - Element `i` is computed from `buf[i]` with scaling `2^-X`.
  - Sign is taken from the input.
  - For `m=|buf[i]|`, the unbiased exponent is `e = msb(m) - frac_bits - X`.
  - If `e >= 1-bias`: normal; keep `man_width` bits below the leading one.
  - Otherwise: subnormal, with LSB weight `2^(1-bias-man_width)`.
  - Rounding is round-to-nearest-even on the discarded bits. A mantissa carry increments the exponent. Subnormal rounding up to the min normal becomes normal.
  - Results above max normal saturate to ±max normal. Inf and NaN are never produced as elements.
  - A zero result (input zero or underflow) is `+0`.
  - If `nan`, every element is `0x00`.
  - `o_last` is 1 for `i==k-1`. After the handshake of the last element, return to COLLECT with `cnt=0`, `mag_or=0`, `nan=0`.
- Blocks do not overlap: no input is accepted during SCALE or EMIT.

## Timing
- Reset values: FSM=COLLECT, `cnt=0`, `o_ready=1`, `o_valid=0`, `o_elem=0`, `o_scale=0`, `o_last=0`, sticky `nan=0`, `mag_or=0`.
- Outputs are registered.
- First `o_valid` asserts 2 cycles after the clock edge that accepts beat `k-1` (SCALE cycle, then element register).
- With `i_ready` held high, one element is emitted per cycle, so `k` cycles per block.
- With `i_ready=0`, `o_elem`, `o_scale`, `o_last` and `o_valid` hold stable.
- `o_valid` never drops without a handshake.
- `i_valid` with `o_ready=0` is ignored, and the upstream is required to hold.
- Reset asserted mid-block discards the partial block immediately and asynchronously. No output is produced for it.

## Test plan
(All scenarios use E5M2 defaults: `frac_bits=32`, `bias=15`.)
- All `k` inputs = `1<<32` (1.0) -> `o_scale=0x70` (X=-15); every element `0x78`; `o_last` on element 31 only.
- Input 0 = `-(3<<32)`, others 0 -> `o_scale=0x71`; element 0 = `0xFA`; others `0x00`.
- Input 0 = `1<<32`, input 1 = `15<<29` (1.875) -> `o_scale=0x70`; element 0 `0x78`; element 1 rounds up, overflows and saturates to `0x7B`.
- All inputs zero -> `o_scale=0x00`, all elements `0x00`. Then `i_nan=1` on beat 7 of the next block -> `o_scale=0xFF`, all elements `0x00`, and `nan` is cleared for the following block.
- Random `i_valid` gaps plus `i_ready` low for 5 cycles mid-EMIT -> outputs stable during the stall, `o_ready=0` throughout SCALE/EMIT, element order preserved; results match a reference model.
- `i_rst_n` pulsed low after 10 beats -> no output for that block, `o_ready=1`. The next full block yields correct results.
